// File: rtl/libhdl_stream_prbs_chk.sv
// libhdl_stream_prbs_chk
// Valid/ready stream sink that drives back-pressure from a rotating stall
// pattern. It locks onto an LFSR data sequence, checks each accepted word,
// and keeps saturating word and error counters plus a sticky error flag.
module libhdl_stream_prbs_chk #(
   parameter int unsigned           DATA_LEN      = 32,
   parameter logic [DATA_LEN-1:0]   TAPS          = 32'h80200003,
   parameter logic [15:0]           STALL_PATTERN = 16'hFFFF,
   parameter int unsigned           RESYNC_THR    = 4,
   parameter int unsigned           CNT_LEN       = 16
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_ena,
   input  logic                i_clr,
   output logic                o_rrdy,
   input  logic                i_rvld,
   input  logic [DATA_LEN-1:0] i_rdat,
   output logic                o_locked,
   output logic                o_err,
   output logic [CNT_LEN-1:0]  o_word_cnt,
   output logic [CNT_LEN-1:0]  o_err_cnt
);

   localparam int unsigned RUN_W = $clog2(RESYNC_THR + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SYNC  = 2'd1,
      CHECK = 2'd2
   } state_t;

   state_t               r_state;
   logic [15:0]          r_rot;
   logic                 r_rrdy;
   logic [DATA_LEN-1:0]  r_exp;
   logic [RUN_W-1:0]     r_run;
   logic                 r_err;
   logic [CNT_LEN-1:0]   r_word_cnt;
   logic [CNT_LEN-1:0]   r_err_cnt;

   logic [15:0]          w_rot_next;
   logic                 w_acc;
   logic                 w_mis;
   logic [RUN_W-1:0]     w_run_inc;
   logic                 w_word_evt;
   logic                 w_err_evt;

   function automatic logic [DATA_LEN-1:0] lfsr_next(input logic [DATA_LEN-1:0] s);
      return {s[DATA_LEN-2:0], ^(s & TAPS)};
   endfunction

   assign w_rot_next = {r_rot[0], r_rot[15:1]};
   assign w_acc      = r_rrdy & i_rvld;
   assign w_mis      = (i_rdat != r_exp);
   assign w_run_inc  = r_run + RUN_W'(1);
   assign w_word_evt = w_acc & (r_state == CHECK);
   assign w_err_evt  = w_word_evt & w_mis;

   // State machine, expected-word LFSR, run counter and ready generator.
   // The next state is IDLE exactly when i_ena is low (IDLE with enable moves
   // to SYNC, SYNC/CHECK never return to IDLE while enabled), so the ready
   // register can be computed from i_ena without a separate next-state net.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_rot   <= STALL_PATTERN;
         r_rrdy  <= 1'b0;
         r_exp   <= '0;
         r_run   <= '0;
      end else begin
         r_rot  <= w_rot_next;
         r_rrdy <= i_ena & w_rot_next[0];
         case (r_state)
            IDLE: r_state <= SYNC;
            SYNC: begin
               if (w_acc) begin
                  r_exp   <= lfsr_next(i_rdat);
                  r_run   <= '0;
                  r_state <= CHECK;
               end
            end
            CHECK: begin
               if (w_acc) begin
                  // Free-running expectation: a single bad word costs one error.
                  r_exp <= lfsr_next(r_exp);
                  if (w_mis) begin
                     r_run <= w_run_inc;
                     if (w_run_inc == RUN_W'(RESYNC_THR))
                        r_state <= SYNC;
                  end else begin
                     r_run <= '0;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
         // Disable wins for the state, but any accept above was still processed.
         if (!i_ena)
            r_state <= IDLE;
      end
   end

   // Saturating counters and sticky error; clear drops a coincident event.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_word_cnt <= '0;
         r_err_cnt  <= '0;
         r_err      <= 1'b0;
      end else begin
         if (w_word_evt && (r_word_cnt != {CNT_LEN{1'b1}}))
            r_word_cnt <= r_word_cnt + CNT_LEN'(1);
         if (w_err_evt && (r_err_cnt != {CNT_LEN{1'b1}}))
            r_err_cnt <= r_err_cnt + CNT_LEN'(1);
         if (w_err_evt)
            r_err <= 1'b1;
      end
   end

   assign o_rrdy     = r_rrdy;
   assign o_locked   = (r_state == CHECK);
   assign o_err      = r_err;
   assign o_word_cnt = r_word_cnt;
   assign o_err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_libhdl_stream_prbs_chk.sv
// Directed bench for libhdl_stream_prbs_chk: default instance (a) for the
// lock/check/resync/disable/clear/reset flow, a 16'h5555 stall-pattern
// instance (b) for back-pressure, and a 4-bit counter instance (c) for
// saturation.
module tb_libhdl_stream_prbs_chk;

   localparam int OP_PUSH = 0;
   localparam int OP_REEN = 1;
   localparam int OP_CLR  = 2;

   typedef struct {
      int          op;
      logic [31:0] d;
      logic        locked;
      int          wc;
      int          ec;
      logic        err;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // instance a
   logic a_ena, a_clr, a_rrdy, a_vld, a_locked, a_err;
   logic [31:0] a_dat;
   logic [15:0] a_wc, a_ec;
   // instance b
   logic b_ena, b_clr, b_rrdy, b_vld, b_locked, b_err;
   logic [31:0] b_dat;
   logic [15:0] b_wc, b_ec;
   // instance c
   logic c_ena, c_clr, c_rrdy, c_vld, c_locked, c_err;
   logic [31:0] c_dat;
   logic [3:0]  c_wc, c_ec;

   int n_chk = 0;
   int n_err = 0;

   libhdl_stream_prbs_chk u_a (
      .i_clk(clk), .i_rst(rst), .i_ena(a_ena), .i_clr(a_clr),
      .o_rrdy(a_rrdy), .i_rvld(a_vld), .i_rdat(a_dat),
      .o_locked(a_locked), .o_err(a_err), .o_word_cnt(a_wc), .o_err_cnt(a_ec));

   libhdl_stream_prbs_chk #(.STALL_PATTERN(16'h5555)) u_b (
      .i_clk(clk), .i_rst(rst), .i_ena(b_ena), .i_clr(b_clr),
      .o_rrdy(b_rrdy), .i_rvld(b_vld), .i_rdat(b_dat),
      .o_locked(b_locked), .o_err(b_err), .o_word_cnt(b_wc), .o_err_cnt(b_ec));

   libhdl_stream_prbs_chk #(.CNT_LEN(4)) u_c (
      .i_clk(clk), .i_rst(rst), .i_ena(c_ena), .i_clr(c_clr),
      .o_rrdy(c_rrdy), .i_rvld(c_vld), .i_rdat(c_dat),
      .o_locked(c_locked), .o_err(c_err), .o_word_cnt(c_wc), .o_err_cnt(c_ec));

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return {s[30:0], ^(s & 32'h80200003)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Present a word on a; it is accepted on the first edge where ready is high.
   task automatic push_a(input logic [31:0] d);
      int n;
      n = 0;
      a_vld = 1'b1;
      a_dat = d;
      while (!a_rrdy && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!a_rrdy) begin
         n_chk++;
         n_err++;
         $display("FAIL a_push_timeout: ready stayed %0b, expected 1", a_rrdy);
      end
      @(negedge clk);
      a_vld = 1'b0;
   endtask

   task automatic push_c(input logic [31:0] d);
      int n;
      n = 0;
      c_vld = 1'b1;
      c_dat = d;
      while (!c_rrdy && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!c_rrdy) begin
         n_chk++;
         n_err++;
         $display("FAIL c_push_timeout: ready stayed %0b, expected 1", c_rrdy);
      end
      @(negedge clk);
      c_vld = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[20];
      logic [31:0] d;
      int sent, cyc, alt_bad;
      logic r, prev, seen;

      tbl[0]  = '{OP_PUSH, 32'h01, 1'b1, 0, 0, 1'b0};
      tbl[1]  = '{OP_PUSH, 32'h03, 1'b1, 1, 0, 1'b0};
      tbl[2]  = '{OP_PUSH, 32'h06, 1'b1, 2, 0, 1'b0};
      tbl[3]  = '{OP_PUSH, 32'h0D, 1'b1, 3, 0, 1'b0};
      tbl[4]  = '{OP_PUSH, 32'h1B, 1'b1, 4, 0, 1'b0};
      tbl[5]  = '{OP_REEN, 32'h00, 1'b0, 4, 0, 1'b0};
      tbl[6]  = '{OP_CLR,  32'h00, 1'b0, 0, 0, 1'b0};
      tbl[7]  = '{OP_PUSH, 32'h01, 1'b1, 0, 0, 1'b0};
      tbl[8]  = '{OP_PUSH, 32'h03, 1'b1, 1, 0, 1'b0};
      tbl[9]  = '{OP_PUSH, 32'h07, 1'b1, 2, 1, 1'b1};
      tbl[10] = '{OP_PUSH, 32'h0D, 1'b1, 3, 1, 1'b1};
      tbl[11] = '{OP_PUSH, 32'h1B, 1'b1, 4, 1, 1'b1};
      tbl[12] = '{OP_CLR,  32'h00, 1'b1, 0, 0, 1'b0};
      tbl[13] = '{OP_PUSH, 32'h00, 1'b1, 1, 1, 1'b1};
      tbl[14] = '{OP_PUSH, 32'h00, 1'b1, 2, 2, 1'b1};
      tbl[15] = '{OP_PUSH, 32'h00, 1'b1, 3, 3, 1'b1};
      tbl[16] = '{OP_PUSH, 32'h00, 1'b0, 4, 4, 1'b1};
      tbl[17] = '{OP_PUSH, 32'h1B, 1'b1, 4, 4, 1'b1};
      tbl[18] = '{OP_PUSH, 32'h36, 1'b1, 5, 4, 1'b1};
      tbl[19] = '{OP_PUSH, 32'h6D, 1'b1, 6, 4, 1'b1};

      rst = 1'b1;
      a_ena = 0; a_clr = 0; a_vld = 0; a_dat = 0;
      b_ena = 0; b_clr = 0; b_vld = 0; b_dat = 0;
      c_ena = 0; c_clr = 0; c_vld = 0; c_dat = 0;
      repeat (3) @(negedge clk);
      chk("rst_rrdy", 32'(a_rrdy), 0);
      chk("rst_locked", 32'(a_locked), 0);
      chk("rst_err", 32'(a_err), 0);
      chk("rst_wc", 32'(a_wc), 0);
      chk("rst_ec", 32'(a_ec), 0);
      rst = 1'b0;
      @(negedge clk);

      // enable: ready rises on the edge that samples i_ena
      a_ena = 1'b1;
      chk("ena_rrdy_before", 32'(a_rrdy), 0);
      @(negedge clk);
      chk("ena_rrdy_after", 32'(a_rrdy), 1);
      chk("ena_locked", 32'(a_locked), 0);

      for (int i = 0; i < 20; i++) begin
         case (tbl[i].op)
            OP_PUSH: push_a(tbl[i].d);
            OP_REEN: begin
               a_ena = 1'b0;
               @(negedge clk);
               a_ena = 1'b1;
               @(negedge clk);
            end
            default: begin
               a_clr = 1'b1;
               @(negedge clk);
               a_clr = 1'b0;
            end
         endcase
         chk($sformatf("vec%0d_locked", i), 32'(a_locked), 32'(tbl[i].locked));
         chk($sformatf("vec%0d_wc", i), 32'(a_wc), tbl[i].wc);
         chk($sformatf("vec%0d_ec", i), 32'(a_ec), tbl[i].ec);
         chk($sformatf("vec%0d_err", i), 32'(a_err), 32'(tbl[i].err));
      end

      // disable mid-stream: the accept on the disabling edge still counts
      a_ena = 1'b0;
      a_vld = 1'b1;
      a_dat = 32'hDB;
      @(negedge clk);
      chk("dis_rrdy", 32'(a_rrdy), 0);
      chk("dis_wc", 32'(a_wc), 7);
      chk("dis_locked", 32'(a_locked), 0);
      repeat (3) @(negedge clk);
      chk("dis_hold_wc", 32'(a_wc), 7);
      chk("dis_hold_ec", 32'(a_ec), 4);
      chk("dis_hold_rrdy", 32'(a_rrdy), 0);
      a_vld = 1'b0;

      a_clr = 1'b1;
      @(negedge clk);
      a_clr = 1'b0;
      chk("clr_wc", 32'(a_wc), 0);
      chk("clr_ec", 32'(a_ec), 0);
      chk("clr_err", 32'(a_err), 0);

      // back-pressure on b
      b_ena = 1'b1;
      b_vld = 1'b1;
      b_dat = 32'h1;
      sent = 0; cyc = 0; alt_bad = 0; prev = 1'b0; seen = 1'b0;
      while (sent < 100 && cyc < 1000) begin
         r = b_rrdy;
         if (seen && r == prev) alt_bad++;
         if (r) seen = 1'b1;
         prev = r;
         @(negedge clk);
         cyc++;
         if (r) begin
            sent++;
            b_dat = lfsr_next(b_dat);
         end
      end
      b_vld = 1'b0;
      chk("bp_sent", sent, 100);
      chk("bp_alternate_violations", alt_bad, 0);
      chk("bp_wc", 32'(b_wc), 99);
      chk("bp_ec", 32'(b_ec), 0);
      chk("bp_locked", 32'(b_locked), 1);
      b_ena = 1'b0;

      // saturation on c
      c_ena = 1'b1;
      @(negedge clk);
      d = 32'h1;
      push_c(d);
      for (int i = 1; i <= 20; i++) begin
         d = lfsr_next(d);
         push_c(d);
         if (i == 15) chk("sat_wc_at15", 32'(c_wc), 15);
      end
      chk("sat_wc_end", 32'(c_wc), 15);
      chk("sat_ec", 32'(c_ec), 0);
      chk("sat_err", 32'(c_err), 0);

      // reset during a pending mismatching transfer
      a_ena = 1'b1;
      @(negedge clk);
      push_a(32'h5);
      chk("pre_rst_locked", 32'(a_locked), 1);
      a_vld = 1'b1;
      a_dat = 32'h0;
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_rrdy", 32'(a_rrdy), 0);
      chk("mid_rst_locked", 32'(a_locked), 0);
      chk("mid_rst_err", 32'(a_err), 0);
      chk("mid_rst_wc", 32'(a_wc), 0);
      chk("mid_rst_ec", 32'(a_ec), 0);
      rst = 1'b0;
      a_ena = 1'b0;
      a_vld = 1'b0;
      @(negedge clk);
      chk("post_rst_rrdy", 32'(a_rrdy), 0);
      chk("post_rst_err", 32'(a_err), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
